// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_ctrl_pkg
// Description : Shared encodings for the ALU-control stage. These include the
//               main-decoder ALU classes, the ALU op codes for RV32I and RV32M,
//               the stage FSM states and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

   // Width of the native op-code table; wider ALU_CTRL_W zero-extends it.
   localparam int CODE_W = 5;

   // ALU class produced by the main decoder.
   typedef enum logic [2:0] {
      AOP_LOAD   = 3'd0,
      AOP_STORE  = 3'd1,
      AOP_R_TYPE = 3'd2,
      AOP_I_TYPE = 3'd3,
      AOP_BRANCH = 3'd4,
      AOP_JUMP   = 3'd5,
      AOP_U_TYPE = 3'd6,
      AOP_NOP    = 3'd7
   } aluop_e;

   // RV32I op codes. They keep the MSB at 0.
   // BLT and BLTU reuse SLT and SLTU, because the EX comparator result is
   // the same. This lets all RV32I codes fit in [3:0].
   localparam logic [CODE_W-1:0] ALU_ADD  = 5'h00;
   localparam logic [CODE_W-1:0] ALU_SUB  = 5'h01;
   localparam logic [CODE_W-1:0] ALU_SLL  = 5'h02;
   localparam logic [CODE_W-1:0] ALU_SLT  = 5'h03;
   localparam logic [CODE_W-1:0] ALU_SLTU = 5'h04;
   localparam logic [CODE_W-1:0] ALU_XOR  = 5'h05;
   localparam logic [CODE_W-1:0] ALU_SRL  = 5'h06;
   localparam logic [CODE_W-1:0] ALU_SRA  = 5'h07;
   localparam logic [CODE_W-1:0] ALU_OR   = 5'h08;
   localparam logic [CODE_W-1:0] ALU_AND  = 5'h09;
   localparam logic [CODE_W-1:0] ALU_BEQ  = 5'h0A;
   localparam logic [CODE_W-1:0] ALU_BNE  = 5'h0B;
   localparam logic [CODE_W-1:0] ALU_BGE  = 5'h0C;
   localparam logic [CODE_W-1:0] ALU_BGEU = 5'h0D;
   localparam logic [CODE_W-1:0] ALU_PC4  = 5'h0E;

   // RV32M op codes: MUL + funct3 spans MUL..REMU (5'h10..5'h17).
   localparam logic [CODE_W-1:0] ALU_MUL    = 5'h10;
   localparam logic [CODE_W-1:0] ALU_MULH   = 5'h11;
   localparam logic [CODE_W-1:0] ALU_MULHSU = 5'h12;
   localparam logic [CODE_W-1:0] ALU_MULHU  = 5'h13;
   localparam logic [CODE_W-1:0] ALU_DIV    = 5'h14;
   localparam logic [CODE_W-1:0] ALU_DIVU   = 5'h15;
   localparam logic [CODE_W-1:0] ALU_REM    = 5'h16;
   localparam logic [CODE_W-1:0] ALU_REMU   = 5'h17;

   // funct7 patterns that are meaningful for OP / OP-IMM shifts.
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // Stage FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MC    = 2'd1,
      ST_VALID = 2'd2
   } state_e;

   // Integer ALU op for a funct3; alt selects SUB/SRA over ADD/SRL.
   function automatic logic [CODE_W-1:0] base_code(input logic [2:0] f3, input logic alt);
      logic [CODE_W-1:0] c;
      case (f3)
         3'b000:  c = alt ? ALU_SUB : ALU_ADD;
         3'b001:  c = ALU_SLL;
         3'b010:  c = ALU_SLT;
         3'b011:  c = ALU_SLTU;
         3'b100:  c = ALU_XOR;
         3'b101:  c = alt ? ALU_SRA : ALU_SRL;
         3'b110:  c = ALU_OR;
         default: c = ALU_AND;
      endcase
      return c;
   endfunction

   // RV32M op code for a funct3.
   function automatic logic [CODE_W-1:0] m_code(input logic [2:0] f3);
      return ALU_MUL | {2'b00, f3};
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Purely combinational ALU-control table. It maps the ALU class,
//               funct3 and funct7 to an op code, an illegal flag and
//               multi-cycle (mul/div) class flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode #(
   parameter int ALU_CTRL_W = 5,
   parameter bit EN_M       = 1'b1
) (
   input  logic [2:0]            aluop_i,
   input  logic [2:0]            funct3_i,
   input  logic [6:0]            funct7_i,
   output logic [ALU_CTRL_W-1:0] code_o,
   output logic                  illegal_o,
   output logic                  is_mul_o,
   output logic                  is_div_o
);
   import alu_ctrl_pkg::*;

   logic [CODE_W-1:0] w_code;
   logic              w_bad;
   logic              w_m_enc;

   assign w_m_enc = (aluop_i == AOP_R_TYPE) && (funct7_i == F7_MULDIV);

   // Table lookup; any undecodable encoding collapses to code 0 with illegal set.
   always_comb begin
      w_code = ALU_ADD;
      w_bad  = 1'b0;
      case (aluop_i)
         AOP_LOAD, AOP_STORE, AOP_U_TYPE, AOP_NOP: w_code = ALU_ADD;
         AOP_JUMP: w_code = ALU_PC4;
         AOP_BRANCH: begin
            case (funct3_i)
               3'b000:  w_code = ALU_BEQ;
               3'b001:  w_code = ALU_BNE;
               3'b100:  w_code = ALU_SLT;
               3'b101:  w_code = ALU_BGE;
               3'b110:  w_code = ALU_SLTU;
               3'b111:  w_code = ALU_BGEU;
               default: w_bad  = 1'b1;
            endcase
         end
         AOP_I_TYPE: begin
            // funct7 is only an opcode field for the immediate shifts.
            w_code = base_code(funct3_i, (funct3_i == 3'b101) && funct7_i[5]);
            if ((funct3_i == 3'b001) && (funct7_i != F7_BASE)) begin
               w_bad = 1'b1;
            end
            if ((funct3_i == 3'b101) && (funct7_i != F7_BASE) && (funct7_i != F7_ALT)) begin
               w_bad = 1'b1;
            end
         end
         AOP_R_TYPE: begin
            if (w_m_enc) begin
               w_code = m_code(funct3_i);
               w_bad  = !EN_M;
            end else if (funct7_i == F7_BASE) begin
               w_code = base_code(funct3_i, 1'b0);
            end else if ((funct7_i == F7_ALT) &&
                         ((funct3_i == 3'b000) || (funct3_i == 3'b101))) begin
               w_code = base_code(funct3_i, 1'b1);
            end else begin
               w_bad = 1'b1;
            end
         end
         default: w_bad = 1'b1;
      endcase
      if (w_bad) begin
         w_code = ALU_ADD;
      end
   end

   assign code_o    = ALU_CTRL_W'(w_code);
   assign illegal_o = w_bad;
   assign is_mul_o  = EN_M && w_m_enc && !funct3_i[2];
   assign is_div_o  = EN_M && w_m_enc &&  funct3_i[2];

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_stage
// Description : Registered ALU-control stage between ID and EX. It decodes the
//               op and holds multi-cycle M ops for their latency, using
//               valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_stage #(
   parameter int ALU_CTRL_W = 5,
   parameter bit EN_M       = 1'b1,
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 33
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            aluop,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  illegal_op,
   output logic                  mc_start
);
   import alu_ctrl_pkg::*;

   localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] c_mul_load = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_div_load = CNT_W'(DIV_CYCLES - 1);

   generate
      if (MUL_CYCLES < 2) begin : g_chk_mul
         $error("alu_ctrl_stage: MUL_CYCLES must be >= 2");
      end
      if (DIV_CYCLES < 2) begin : g_chk_div
         $error("alu_ctrl_stage: DIV_CYCLES must be >= 2");
      end
      if (ALU_CTRL_W < CODE_W) begin : g_chk_w
         $error("alu_ctrl_stage: ALU_CTRL_W must be >= 5");
      end
   endgenerate

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ALU_CTRL_W-1:0] code_q, code_d;
   logic                  illegal_q, illegal_d;
   logic                  mc_start_q, mc_start_d;

   logic [ALU_CTRL_W-1:0] w_dec_code;
   logic                  w_dec_illegal;
   logic                  w_dec_is_mul;
   logic                  w_dec_is_div;
   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_capture;

   alu_ctrl_decode #(
      .ALU_CTRL_W (ALU_CTRL_W),
      .EN_M       (EN_M)
   ) u_decode (
      .aluop_i    (aluop),
      .funct3_i   (funct3),
      .funct7_i   (funct7),
      .code_o     (w_dec_code),
      .illegal_o  (w_dec_illegal),
      .is_mul_o   (w_dec_is_mul),
      .is_div_o   (w_dec_is_div)
   );

   // Upstream ready: open in IDLE, pass-through of out_ready in VALID, never under flush/reset.
   always_comb begin
      w_in_ready = 1'b0;
      case (state_q)
         ST_IDLE:  w_in_ready = 1'b1;
         ST_VALID: w_in_ready = out_ready;
         default:  w_in_ready = 1'b0;
      endcase
      if (flush || rst) begin
         w_in_ready = 1'b0;
      end
   end

   assign w_accept = in_valid && w_in_ready;

   // Next-state: capture on accept, count down M latency, drain on consume; flush wins.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      code_d     = code_q;
      illegal_d  = illegal_q;
      mc_start_d = 1'b0;
      w_capture  = 1'b0;
      case (state_q)
         ST_IDLE: w_capture = w_accept;
         ST_MC: begin
            if (cnt_q == '0) begin
               state_d = ST_VALID;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_VALID: begin
            if (out_ready) begin
               if (w_accept) begin
                  w_capture = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (w_capture) begin
         code_d    = w_dec_code;
         illegal_d = w_dec_illegal;
         if (w_dec_is_mul || w_dec_is_div) begin
            state_d    = ST_MC;
            cnt_d      = w_dec_is_div ? c_div_load : c_mul_load;
            mc_start_d = 1'b1;
         end else begin
            state_d = ST_VALID;
            cnt_d   = '0;
         end
      end
      if (flush) begin
         state_d    = ST_IDLE;
         cnt_d      = '0;
         mc_start_d = 1'b0;
      end
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         code_q     <= '0;
         illegal_q  <= 1'b0;
         mc_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         code_q     <= code_d;
         illegal_q  <= illegal_d;
         mc_start_q <= mc_start_d;
      end
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = (state_q == ST_VALID);
   assign alu_control = code_q;
   assign illegal_op  = illegal_q;
   assign mc_start    = mc_start_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_stage
// Description : Directed self-checking bench for alu_ctrl_stage, using a
//               queue scoreboard of expected op codes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_stage;

   localparam logic [2:0] OP_LOAD = 3'd0, OP_STORE = 3'd1, OP_R = 3'd2, OP_I = 3'd3;
   localparam logic [2:0] OP_BR = 3'd4, OP_JUMP = 3'd5, OP_U = 3'd6, OP_NOP = 3'd7;

   localparam logic [4:0] C_ADD = 5'h00, C_SUB = 5'h01, C_SLL = 5'h02, C_SLT = 5'h03;
   localparam logic [4:0] C_SLTU = 5'h04, C_XOR = 5'h05, C_SRL = 5'h06, C_SRA = 5'h07;
   localparam logic [4:0] C_OR = 5'h08, C_AND = 5'h09, C_EQ = 5'h0A, C_NE = 5'h0B;
   localparam logic [4:0] C_GE = 5'h0C, C_GEU = 5'h0D, C_PC4 = 5'h0E;

   localparam int N_SWEEP = 26;

   logic       clk;
   logic       rst, in_valid, flush, out_ready;
   logic [2:0] aluop, funct3;
   logic [6:0] funct7;

   logic       in_ready, out_valid, illegal_op, mc_start;
   logic [4:0] alu_control;
   logic       n_in_ready, n_out_valid, n_illegal_op, n_mc_start;
   logic [4:0] n_alu_control;

   typedef struct packed {
      logic       ill;
      logic [4:0] code;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [12:0] sweep [0:N_SWEEP-1];

   alu_ctrl_stage #(
      .ALU_CTRL_W (5), .EN_M (1'b1), .MUL_CYCLES (2), .DIV_CYCLES (33)
   ) dut (
      .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
      .aluop (aluop), .funct3 (funct3), .funct7 (funct7), .flush (flush),
      .out_valid (out_valid), .out_ready (out_ready), .alu_control (alu_control),
      .illegal_op (illegal_op), .mc_start (mc_start)
   );

   alu_ctrl_stage #(
      .ALU_CTRL_W (5), .EN_M (1'b0), .MUL_CYCLES (2), .DIV_CYCLES (33)
   ) dut_nom (
      .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (n_in_ready),
      .aluop (aluop), .funct3 (funct3), .funct7 (funct7), .flush (flush),
      .out_valid (n_out_valid), .out_ready (out_ready), .alu_control (n_alu_control),
      .illegal_op (n_illegal_op), .mc_start (n_mc_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode written from the RV32I/M opcode tables.
   function automatic exp_t model(input logic [2:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic en_m);
      exp_t e;
      e.ill  = 1'b0;
      e.code = C_ADD;
      case (op)
         OP_JUMP: e.code = C_PC4;
         OP_BR: begin
            case (f3)
               3'd0: e.code = C_EQ;
               3'd1: e.code = C_NE;
               3'd4: e.code = C_SLT;
               3'd5: e.code = C_GE;
               3'd6: e.code = C_SLTU;
               3'd7: e.code = C_GEU;
               default: e.ill = 1'b1;
            endcase
         end
         OP_I: begin
            case (f3)
               3'd0: e.code = C_ADD;
               3'd1: if (f7 == 7'h00) e.code = C_SLL; else e.ill = 1'b1;
               3'd2: e.code = C_SLT;
               3'd3: e.code = C_SLTU;
               3'd4: e.code = C_XOR;
               3'd5: begin
                  if (f7 == 7'h00) e.code = C_SRL;
                  else if (f7 == 7'h20) e.code = C_SRA;
                  else e.ill = 1'b1;
               end
               3'd6: e.code = C_OR;
               default: e.code = C_AND;
            endcase
         end
         OP_R: begin
            if (f7 == 7'h01) begin
               if (en_m) e.code = 5'h10 + {2'b00, f3};
               else e.ill = 1'b1;
            end else if (f7 == 7'h00) begin
               case (f3)
                  3'd0: e.code = C_ADD;
                  3'd1: e.code = C_SLL;
                  3'd2: e.code = C_SLT;
                  3'd3: e.code = C_SLTU;
                  3'd4: e.code = C_XOR;
                  3'd5: e.code = C_SRL;
                  3'd6: e.code = C_OR;
                  default: e.code = C_AND;
               endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
               e.code = C_SUB;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
               e.code = C_SRA;
            end else begin
               e.ill = 1'b1;
            end
         end
         default: e.code = C_ADD;
      endcase
      if (e.ill) e.code = 5'h00;
      return e;
   endfunction

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk_v(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_op(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
      in_valid = 1'b1;
      aluop    = op;
      funct3   = f3;
      funct7   = f7;
   endtask

   // One clock: scoreboard bookkeeping for the coming edge, then return at the next negedge.
   task automatic tick();
      exp_t e;
      #1;
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk_b("sb_spurious_out_valid", out_valid, 1'b0);
         end else begin
            e = sb_q.pop_front();
            chk_v("sb_code", alu_control, e.code);
            chk_b("sb_illegal", illegal_op, e.ill);
         end
      end
      if (rst || flush) begin
         sb_q.delete();
      end else if (in_valid && in_ready) begin
         sb_q.push_back(model(aluop, funct3, funct7, 1'b1));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sweep = '{
         {OP_I, 3'd1, 7'h00}, {OP_I, 3'd5, 7'h20}, {OP_I, 3'd5, 7'h00}, {OP_I, 3'd2, 7'h33},
         {OP_I, 3'd6, 7'h7F}, {OP_I, 3'd7, 7'h01}, {OP_R, 3'd1, 7'h00}, {OP_R, 3'd3, 7'h00},
         {OP_R, 3'd6, 7'h00}, {OP_R, 3'd7, 7'h00}, {OP_R, 3'd5, 7'h20}, {OP_R, 3'd5, 7'h00},
         {OP_BR, 3'd0, 7'h00}, {OP_BR, 3'd1, 7'h00}, {OP_BR, 3'd4, 7'h00}, {OP_BR, 3'd5, 7'h00},
         {OP_BR, 3'd6, 7'h00}, {OP_BR, 3'd7, 7'h00}, {OP_BR, 3'd2, 7'h00}, {OP_JUMP, 3'd3, 7'h11},
         {OP_LOAD, 3'd2, 7'h40}, {OP_STORE, 3'd2, 7'h7F}, {OP_U, 3'd7, 7'h2A}, {OP_R, 3'd1, 7'h20},
         {OP_R, 3'd0, 7'h10}, {OP_I, 3'd1, 7'h20}
      };

      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      aluop = OP_NOP; funct3 = 3'd0; funct7 = 7'd0;
      @(negedge clk);
      tick();
      tick();

      // Reset state.
      rst = 1'b0;
      #1;
      chk_b("rst_out_valid", out_valid, 1'b0);
      chk_v("rst_alu_control", alu_control, 5'h00);
      chk_b("rst_illegal_op", illegal_op, 1'b0);
      chk_b("rst_in_ready", in_ready, 1'b1);
      chk_b("rst_mc_start", mc_start, 1'b0);

      // ADD, ADD, SUB back-to-back with no bubble.
      for (int k = 0; k < 3; k++) begin
         set_op(OP_R, 3'd0, (k == 2) ? 7'h20 : 7'h00);
         #1;
         chk_b("b2b_in_ready", in_ready, 1'b1);
         tick();
         chk_b("b2b_out_valid", out_valid, 1'b1);
      end
      chk_v("sub_code", alu_control, C_SUB);
      in_valid = 1'b0;
      tick();
      chk_b("drain_out_valid", out_valid, 1'b0);

      // Decode sweep, back-to-back through the scoreboard.
      for (int k = 0; k < N_SWEEP; k++) begin
         set_op(sweep[k][12:10], sweep[k][9:7], sweep[k][6:0]);
         tick();
         chk_b("sweep_out_valid", out_valid, 1'b1);
      end
      in_valid = 1'b0;
      tick();

      // DIV: 33-cycle latency, in_ready low throughout.
      set_op(OP_R, 3'd4, 7'h01);
      tick();
      in_valid = 1'b0;
      chk_b("div_mc_start", mc_start, 1'b1);
      chk_b("div_in_ready0", in_ready, 1'b0);
      chk_b("div_out_valid0", out_valid, 1'b0);
      for (int k = 1; k < 33; k++) begin
         tick();
         chk_b("div_wait_mc_start", mc_start, 1'b0);
         chk_b("div_wait_in_ready", in_ready, 1'b0);
         chk_b("div_wait_out_valid", out_valid, 1'b0);
      end
      tick();
      chk_b("div_out_valid", out_valid, 1'b1);
      chk_v("div_code", alu_control, 5'h14);

      // From VALID, accept a MUL: 2-cycle latency.
      set_op(OP_R, 3'd0, 7'h01);
      tick();
      in_valid = 1'b0;
      chk_b("mul_mc_start", mc_start, 1'b1);
      chk_b("mul_out_valid0", out_valid, 1'b0);
      tick();
      chk_b("mul_mc_start_low", mc_start, 1'b0);
      chk_b("mul_out_valid1", out_valid, 1'b0);
      tick();
      chk_b("mul_out_valid", out_valid, 1'b1);
      chk_v("mul_code", alu_control, 5'h10);

      // From VALID, accept a REM back-to-back.
      set_op(OP_R, 3'd6, 7'h01);
      tick();
      in_valid = 1'b0;
      chk_b("rem_mc_start", mc_start, 1'b1);
      for (int k = 1; k < 33; k++) begin
         tick();
         chk_b("rem_wait_out_valid", out_valid, 1'b0);
      end
      tick();
      chk_b("rem_out_valid", out_valid, 1'b1);
      chk_v("rem_code", alu_control, 5'h16);
      tick();

      // Flush 10 cycles into a DIV, then a new ADDI.
      set_op(OP_R, 3'd5, 7'h01);
      tick();
      in_valid = 1'b0;
      for (int k = 1; k < 10; k++) tick();
      flush = 1'b1;
      set_op(OP_I, 3'd0, 7'h55);
      #1;
      chk_b("flush_in_ready", in_ready, 1'b0);
      tick();
      flush = 1'b0;
      #1;
      chk_b("post_flush_out_valid", out_valid, 1'b0);
      chk_b("post_flush_in_ready", in_ready, 1'b1);
      chk_b("post_flush_mc_start", mc_start, 1'b0);
      tick();
      chk_b("addi_out_valid", out_valid, 1'b1);
      chk_v("addi_code", alu_control, C_ADD);
      chk_b("addi_illegal", illegal_op, 1'b0);
      in_valid = 1'b0;
      tick();

      // Backpressure: VALID held while out_ready=0.
      set_op(OP_R, 3'd4, 7'h00);
      tick();
      out_ready = 1'b0;
      set_op(OP_I, 3'd3, 7'h00);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk_b("bp_in_ready", in_ready, 1'b0);
         tick();
         chk_b("bp_out_valid", out_valid, 1'b1);
         chk_v("bp_code_stable", alu_control, C_XOR);
      end
      out_ready = 1'b1;
      #1;
      chk_b("bp_release_in_ready", in_ready, 1'b1);
      tick();
      chk_b("bp_next_out_valid", out_valid, 1'b1);
      chk_v("bp_next_code", alu_control, C_SLTU);
      in_valid = 1'b0;
      tick();
      chk_b("bp_drain_out_valid", out_valid, 1'b0);

      // EN_M=0: an M encoding is flagged illegal as a single-cycle op.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_op(OP_R, 3'd0, 7'h01);
      tick();
      in_valid = 1'b0;
      chk_b("nom_out_valid", n_out_valid, 1'b1);
      chk_b("nom_illegal", n_illegal_op, 1'b1);
      chk_v("nom_code", n_alu_control, 5'h00);
      chk_b("nom_mc_start", n_mc_start, 1'b0);
      tick();
      chk_b("nom_mc_start_after", n_mc_start, 1'b0);
      chk_b("nom_drain_out_valid", n_out_valid, 1'b0);
      tick();
      tick();
      chk_i("sb_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
